// File: rtl/matrix_write_sequencer.sv
// Write-side sequencer for the modulation-matrix register file: arbitrates host single writes vs bulk row-major load.
// Latency: accept in cycle N -> one-hot wren/wr_data in N+1; bulk stalls host via h_ready, b_start wins over host.
module matrix_write_sequencer #(
   parameter int DW   = 24,
   parameter int RW   = 4,
   parameter int CW   = 4,
   parameter int AW_R = (RW > 1) ? $clog2(RW) : 1,
   parameter int AW_C = (CW > 1) ? $clog2(CW) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             h_valid,
   output logic             h_ready,
   input  logic [AW_R-1:0]  h_row,
   input  logic [AW_C-1:0]  h_col,
   input  logic [DW-1:0]    h_data,
   output logic             h_err,
   input  logic             b_start,
   input  logic             b_abort,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [DW-1:0]    b_data,
   output logic             b_done,
   output logic             b_aborted,
   output logic             busy,
   output logic [RW*CW-1:0] wren,
   output logic [DW-1:0]    wr_data
);

   localparam int NE = RW * CW;

   typedef enum logic {IDLE, BULK} state_t;

   state_t            state, state_nxt;
   logic [AW_R-1:0]   r_q, r_nxt;
   logic [AW_C-1:0]   c_q, c_nxt;
   logic              wr_en;
   int                wr_idx;
   logic [DW-1:0]     wr_src;
   logic [NE-1:0]     wren_nxt;
   logic              herr_nxt, done_nxt, abort_nxt;

   always_comb begin
      state_nxt = state;
      r_nxt     = r_q;
      c_nxt     = c_q;
      h_ready   = 1'b0;
      b_ready   = 1'b0;
      wr_en     = 1'b0;
      wr_idx    = 0;
      wr_src    = h_data;
      herr_nxt  = 1'b0;
      done_nxt  = 1'b0;
      abort_nxt = 1'b0;
      if (state == IDLE) begin
         h_ready = !b_start;
         if (b_start) begin
            state_nxt = BULK;
            r_nxt     = '0;
            c_nxt     = '0;
         end else if (h_valid) begin
            // Out-of-range host writes are still consumed, only flagged.
            if (int'(h_row) < RW && int'(h_col) < CW) begin
               wr_en  = 1'b1;
               wr_idx = int'(h_row) * CW + int'(h_col);
            end else begin
               herr_nxt = 1'b1;
            end
         end
      end else begin
         b_ready = 1'b1;
         if (b_abort) begin
            // An element offered alongside the abort is dropped.
            state_nxt = IDLE;
            r_nxt     = '0;
            c_nxt     = '0;
            abort_nxt = 1'b1;
         end else if (b_valid) begin
            wr_en  = 1'b1;
            wr_idx = int'(r_q) * CW + int'(c_q);
            wr_src = b_data;
            if (c_q == AW_C'(CW - 1)) begin
               c_nxt = '0;
               if (r_q == AW_R'(RW - 1)) begin
                  state_nxt = IDLE;
                  r_nxt     = '0;
                  done_nxt  = 1'b1;
               end else begin
                  r_nxt = r_q + 1'b1;
               end
            end else begin
               c_nxt = c_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      wren_nxt = '0;
      for (int i = 0; i < NE; i++) begin
         if (wr_en && wr_idx == i) wren_nxt[i] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r_q       <= '0;
         c_q       <= '0;
         wren      <= '0;
         wr_data   <= '0;
         h_err     <= 1'b0;
         b_done    <= 1'b0;
         b_aborted <= 1'b0;
      end else begin
         state     <= state_nxt;
         r_q       <= r_nxt;
         c_q       <= c_nxt;
         wren      <= wren_nxt;
         if (wr_en) wr_data <= wr_src;
         h_err     <= herr_nxt;
         b_done    <= done_nxt;
         b_aborted <= abort_nxt;
      end
   end

   assign busy = (state == BULK);

endmodule

// File: tb/tb_matrix_write_sequencer.sv
// Randomized + directed bench for matrix_write_sequencer against an element-count reference model.
module tb_matrix_write_sequencer;

   localparam int DW = 24;
   localparam int NE = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          h_valid, h_ready, h_err;
   logic [1:0]    h_row, h_col;
   logic [DW-1:0] h_data, b_data, wr_data;
   logic          b_start, b_abort, b_valid, b_ready, b_done, b_aborted, busy;
   logic [NE-1:0] wren;

   logic          h3_valid, h3_ready, h3_err;
   logic [1:0]    h3_row, h3_col;
   logic [DW-1:0] h3_data, b3_data, wr_data3;
   logic          b3_start, b3_abort, b3_valid, b3_ready, b3_done, b3_aborted, busy3;
   logic [8:0]    wren3;

   int n_chk = 0;
   int n_err = 0;

   // reference model: load in progress flag, next element index, last written data
   bit            m_active;
   int            m_k;
   logic [DW-1:0] m_wd;

   always #5 clk = ~clk;

   matrix_write_sequencer dut (
      .clk(clk), .rst_n(rst_n),
      .h_valid(h_valid), .h_ready(h_ready), .h_row(h_row), .h_col(h_col), .h_data(h_data), .h_err(h_err),
      .b_start(b_start), .b_abort(b_abort), .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
      .b_done(b_done), .b_aborted(b_aborted), .busy(busy), .wren(wren), .wr_data(wr_data)
   );

   matrix_write_sequencer #(.DW(DW), .RW(3), .CW(3)) dut3 (
      .clk(clk), .rst_n(rst_n),
      .h_valid(h3_valid), .h_ready(h3_ready), .h_row(h3_row), .h_col(h3_col), .h_data(h3_data), .h_err(h3_err),
      .b_start(b3_start), .b_abort(b3_abort), .b_valid(b3_valid), .b_ready(b3_ready), .b_data(b3_data),
      .b_done(b3_done), .b_aborted(b3_aborted), .busy(busy3), .wren(wren3), .wr_data(wr_data3)
   );

   task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check handshakes with current inputs, predict, then check registered outputs.
   task automatic step();
      logic [NE-1:0] ew;
      bit eherr, edone, eab;
      int idx;
      ew = '0; eherr = 0; edone = 0; eab = 0;
      #1;
      chk("h_ready", h_ready, (!m_active && !b_start));
      chk("b_ready", b_ready, m_active);
      if (!m_active) begin
         if (b_start) begin
            m_active = 1;
            m_k      = 0;
         end else if (h_valid) begin
            idx = int'(h_row) * 4 + int'(h_col);
            ew[idx] = 1'b1;
            m_wd = h_data;
         end
      end else if (b_abort) begin
         m_active = 0;
         eab = 1;
      end else if (b_valid) begin
         ew[m_k] = 1'b1;
         m_wd = b_data;
         m_k++;
         if (m_k == NE) begin
            m_active = 0;
            edone = 1;
         end
      end
      @(posedge clk);
      #1;
      chk("wren", wren, ew);
      chk("wr_data", wr_data, m_wd);
      chk("h_err", h_err, eherr);
      chk("b_done", b_done, edone);
      chk("b_aborted", b_aborted, eab);
      chk("busy", busy, m_active);
   endtask

   initial begin
      rst_n = 1'b0;
      h_valid = 0; h_row = 0; h_col = 0; h_data = 0;
      b_start = 0; b_abort = 0; b_valid = 0; b_data = 0;
      h3_valid = 0; h3_row = 0; h3_col = 0; h3_data = 0;
      b3_start = 0; b3_abort = 0; b3_valid = 0; b3_data = 0;
      m_active = 0; m_k = 0; m_wd = '0;
      #12;
      chk("rst_wren", wren, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_h_err", h_err, 0);
      chk("rst_b_done", b_done, 0);
      chk("rst_b_aborted", b_aborted, 0);
      chk("rst_b_ready", b_ready, 0);
      rst_n = 1'b1;

      // 3x3 instance: out-of-range host writes are consumed and flagged
      @(negedge clk);
      h3_valid = 1; h3_row = 3; h3_col = 3; h3_data = 24'h111111;
      #1 chk("h3_ready", h3_ready, 1);
      @(posedge clk); #1;
      chk("h3_err_oor", h3_err, 1);
      chk("h3_wren_oor", wren3, 0);
      h3_row = 2; h3_col = 2; h3_data = 24'h123456;
      @(posedge clk); #1;
      chk("h3_err_ok", h3_err, 0);
      chk("h3_wren_ok", wren3, 9'h100);
      chk("h3_wr_data", wr_data3, 24'h123456);
      h3_row = 1; h3_col = 3; h3_data = 24'h222222;
      @(posedge clk); #1;
      h3_valid = 0;
      chk("h3_err_col", h3_err, 1);
      chk("h3_wren_col", wren3, 0);
      chk("h3_wr_data_hold", wr_data3, 24'h123456);

      // host write to (2,1): bit 9
      h_valid = 1; h_row = 2; h_col = 1; h_data = 24'hABCDEF;
      step();
      h_valid = 0;
      step();

      // b_start beats a simultaneous host request; host held through full load
      h_valid = 1; h_row = 1; h_col = 0; h_data = 24'h5A5A5A; b_start = 1;
      step();
      b_start = 0;
      for (int i = 0; i < NE; i++) begin
         b_valid = 1; b_data = DW'(i);
         step();
      end
      b_valid = 0;
      step();
      h_valid = 0;
      step();

      // abort after 5 elements with a 6th offered
      b_start = 1; step(); b_start = 0;
      for (int i = 0; i < 5; i++) begin
         b_valid = 1; b_data = DW'(32'h100 + i);
         step();
      end
      b_abort = 1; b_data = 24'h1FF;
      step();
      b_abort = 0; b_valid = 0;
      step();
      b_start = 1; step(); b_start = 0;
      for (int i = 0; i < NE; i++) begin
         b_valid = 1; b_data = DW'(32'h700 + i);
         step();
      end
      b_valid = 0;
      step();

      // randomized traffic
      for (int n = 0; n < 600; n++) begin
         b_start = ($urandom_range(0, 15) == 0);
         b_abort = ($urandom_range(0, 31) == 0);
         b_valid = ($urandom_range(0, 3) != 0);
         b_data  = DW'($urandom);
         h_valid = $urandom_range(0, 1);
         h_row   = 2'($urandom);
         h_col   = 2'($urandom);
         h_data  = DW'($urandom);
         step();
      end

      // async reset in the middle of a load
      h_valid = 0; b_abort = 0; b_valid = 0;
      b_start = 1; step(); b_start = 0;
      for (int i = 0; i < 3; i++) begin
         b_valid = 1; b_data = DW'(32'h900 + i);
         step();
      end
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wren", wren, 0);
      chk("arst_wr_data", wr_data, 0);
      chk("arst_busy", busy, 0);
      chk("arst_b_done", b_done, 0);
      chk("arst_b_aborted", b_aborted, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_active = 0; m_k = 0; m_wd = '0;
      b_valid = 0;
      for (int i = 0; i < 3; i++) step();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/matrix_write_sequencer.md
Name: matrix_write_sequencer

Overview:
- Owns the write side of the modulation-matrix register file and shares it between two requesters.
- The host/config port issues single addressed element writes.
- The bulk port streams a full matrix in row-major order (patch load).
- The block arbitrates between the two, converts accepted writes into a registered one-hot element write-enable plus broadcast data, and reports load completion and abort.

Parameters:
- DW, 24, element data width.
- RW, 4, matrix rows.
- CW, 4, matrix columns.
- AW_R, $clog2(RW) (min 1), row index width.
- AW_C, $clog2(CW) (min 1), column index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- h_valid  in  1  host write request.
- h_ready  out  1  host write accepted when h_valid&&h_ready.
- h_row  in  AW_R  host target row.
- h_col  in  AW_C  host target column.
- h_data  in  DW  host write data.
- h_err  out  1  one-cycle pulse: accepted host write had row>=RW or col>=CW, so it was dropped.
- b_start  in  1  pulse: begin bulk load.
- b_abort  in  1  pulse: cancel bulk load in progress.
- b_valid  in  1  bulk element valid.
- b_ready  out  1  bulk element accepted when b_valid&&b_ready.
- b_data  in  DW  bulk element data.
- b_done  out  1  one-cycle pulse after the last (RW*CW-th) element is written.
- b_aborted  out  1  one-cycle pulse when a bulk load is cancelled.
- busy  out  1  high while in state BULK.
- wren  out  RW*CW  one-hot element write enable; bit index = row*CW+col.
- wr_data  out  DW  data for the asserted wren bit (broadcast to all elements).

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, row/col counters=0.
  - wren=0, wr_data=0.
  - h_err, b_done, b_aborted, busy all 0.
  - Outputs are valid the cycle after rst_n deasserts.
  - Asserting reset mid-bulk abandons the load silently: no b_aborted pulse.
- States: IDLE, BULK.
- IDLE:
  - h_ready=1 unless b_start=1 in the same cycle; b_start has priority over a host write.
  - b_ready=0.
  - b_start → BULK with counters cleared to 0.
  - Bulk elements arriving while in IDLE are not accepted.
- BULK:
  - h_ready=0 (host stalls; the request must be held).
  - b_ready=1.
  - Each accepted element writes counter position (r,c), then advances c.
  - c wraps to 0 at CW-1 and r increments.
  - Acceptance at (RW-1,CW-1) → IDLE, and b_done pulses in the same cycle as that element's wren.
  - b_start while in BULK is ignored.
- Abort:
  - b_abort in BULK → IDLE, counters cleared, b_aborted pulses the next cycle.
  - An element accepted in the same cycle as b_abort is discarded: no wren.
  - Elements already written stay written.
  - b_abort in IDLE is ignored.
- Write latency:
  - Accept in cycle N → wren one-hot bit and wr_data registered, visible in cycle N+1 for exactly one cycle.
  - wren is all-zero in every other cycle; at most one bit is ever set.
  - Back-to-back accepts give back-to-back single-cycle wren pulses, one element per cycle throughput.
- Host range check:
  - An out-of-range h_row or h_col is still accepted.
  - No wren is produced; h_err pulses in N+1.
- The last-element bulk cycle returns to IDLE, so a held host request is accepted in the following cycle.
- wr_data holds its last value when wren=0.

Test Plan:
- Reset, then host write (row=2,col=1,data=0xABCDEF) → h_ready=1, next cycle wren=bit 9 only, wr_data=0xABCDEF, 1 cycle.
- b_start, then 16 consecutive b_valid with data 0..15 → wren walks bits 0..15 one per cycle with wr_data=index, busy=1 throughout, b_done with the bit-15 write, busy=0 afterwards.
- Host request held during a bulk load → h_ready=0 for all 16 bulk cycles; host write appears on wren exactly one cycle after the first IDLE accept.
- b_start and h_valid in the same IDLE cycle → host not accepted that cycle, bulk proceeds, host completes after b_done.
- Bulk with 5 elements then b_abort together with a 6th element → wren bits 0..4 only, b_aborted next cycle, next b_start restarts at bit 0.
- Host write with row=3,col=3 when RW=3 → accepted, wren stays 0, h_err pulses; async reset mid-bulk → all outputs 0 immediately, no b_done or b_aborted.
